// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchronizer followed by an independent per-bit
// debouncer for a bank of slide switches. Emits registered debounced levels,
// one-cycle rise/fall pulses per bit and an any-change strobe.
module sw_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 200000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] db_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    // Two-flop synchronizer; nothing sits between the stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Next-state per bit: any agreement clears the count, the last
    // consecutive disagreement flips the level and raises the matching pulse.
    always_comb begin
        db_nxt   = sw_db;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int unsigned i = 0; i < unsigned'(WIDTH); i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != sw_db[i]) begin
                if (cnt[i] == LAST) begin
                    db_nxt[i]   = sync2[i];
                    rise_nxt[i] = sync2[i];
                    fall_nxt[i] = ~sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debouncer state and registered outputs; sw_chg is taken from the
    // next-state pulses so it lands in the same cycle as sw_rise/sw_fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_db   <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            sw_chg  <= 1'b0;
            for (int unsigned i = 0; i < unsigned'(WIDTH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_db   <= db_nxt;
            sw_rise <= rise_nxt;
            sw_fall <= fall_nxt;
            sw_chg  <= |(rise_nxt | fall_nxt);
            for (int unsigned i = 0; i < unsigned'(WIDTH); i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce: directed scenarios plus random bouncing,
// checked by a scoreboard fed from a history-window reference model.
module tb_sw_debounce;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_chg;

    sw_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_raw (sw_raw),
        .sw_db  (sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_chg (sw_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   rise0_cnt = 0;
    int   flip1_cnt = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit flips once the last S synchronized samples
    // (since reset) all disagree with its current debounced level.
    logic [W-1:0] m_s1, m_s2, m_db, nd;
    logic [W-1:0] hist[$];
    logic         all_diff;
    exp_t         e_new;
    initial begin
        m_s1 = '0; m_s2 = '0; m_db = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_s1 = '0; m_s2 = '0; m_db = '0;
                hist.delete();
                e_new.db = '0; e_new.rise = '0; e_new.fall = '0; e_new.chg = 1'b0;
            end else begin
                hist.push_back(m_s2);
                if (hist.size() > S) void'(hist.pop_front());
                nd = m_db;
                if (hist.size() == S) begin
                    for (int b = 0; b < W; b++) begin
                        all_diff = 1'b1;
                        foreach (hist[k]) if (hist[k][b] == m_db[b]) all_diff = 1'b0;
                        if (all_diff) nd[b] = ~m_db[b];
                    end
                end
                e_new.db   = nd;
                e_new.rise = nd & ~m_db;
                e_new.fall = ~nd & m_db;
                e_new.chg  = |(e_new.rise | e_new.fall);
                m_s2 = m_s1;
                m_s1 = sw_raw;
                m_db = nd;
            end
            expq.push_back(e_new);
        end
    end

    // Monitor: compares every registered output cycle against the scoreboard.
    exp_t e_pop;
    initial begin
        forever begin
            @(negedge clk);
            while (expq.size() > 0) begin
                e_pop = expq.pop_front();
                chk("sw_db",   sw_db,   e_pop.db);
                chk("sw_rise", sw_rise, e_pop.rise);
                chk("sw_fall", sw_fall, e_pop.fall);
                chk("sw_chg",  {7'b0, sw_chg}, {7'b0, e_pop.chg});
            end
            if (sw_rise[0] === 1'b1) rise0_cnt++;
            if (sw_rise[1] === 1'b1 || sw_fall[1] === 1'b1) flip1_cnt++;
        end
    end

    task automatic drive(input logic [W-1:0] v, input int n);
        repeat (n) begin
            @(negedge clk);
            sw_raw = v;
        end
    endtask

    int dwell;
    initial begin
        rst    = 1'b1;
        sw_raw = 8'hFF;
        // Reset held with switches high, then re-acquisition.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(8'hFF, 10);
        // Clean step up from all-zero.
        drive(8'h00, 10);
        drive(8'b10010101, 10);
        // Bounce rejection on bit 0.
        drive(8'h00, 10);
        rise0_cnt = 0;
        drive(8'h01, 3); drive(8'h00, 3); drive(8'h01, 3); drive(8'h00, 3);
        drive(8'h01, 12);
        chk("bounce_rise0_pulses", rise0_cnt[W-1:0], 8'd1);
        // Fall on several bits at once.
        drive(8'b10010101, 10);
        drive(8'b00000001, 10);
        // Reset in the middle of a pending rise on bit 7.
        drive(8'h00, 10);
        drive(8'h80, 4);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        drive(8'h80, 10);
        // Threshold: 3-cycle disagreement ignored, 4-cycle one accepted.
        drive(8'h00, 10);
        flip1_cnt = 0;
        drive(8'h02, 3);
        drive(8'h00, 10);
        chk("glitch3_no_flip", flip1_cnt[W-1:0], 8'd0);
        drive(8'h02, 4);
        drive(8'h00, 12);
        chk("glitch4_flip_and_back", flip1_cnt[W-1:0], 8'd2);
        // Random bouncing with occasional resets.
        for (int n = 0; n < 120; n++) begin
            dwell = int'($urandom_range(1, 7));
            @(negedge clk);
            rst = ($urandom_range(0, 29) == 0);
            drive(W'($urandom), dwell);
            rst = 1'b0;
        end
        drive(8'h5A, 12);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", W'(expq.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
